// File: rtl/lcd_pkg.sv
// Shared LCD bus package.
// Holds the read-engine state encoding plus the RS/RW pin encodings and the
// busy-flag bit position. The display/write path imports the same package so
// both sides of the LCD bus agree on pin meanings.
package lcd_pkg;

  // Read-engine phases, in the order a single bus read walks through them
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    RECOVER,
    DONE
  } lcd_state_t;

  // Register select: command/status register versus DDRAM/CGRAM data
  localparam logic LCD_RS_CMD   = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;

  // Read/write pin encoding
  localparam logic LCD_RW_WRITE = 1'b0;
  localparam logic LCD_RW_READ  = 1'b1;

  // Busy flag position within a status (RS=0) read
  localparam int   BF_BIT       = 7;

endpackage : lcd_pkg

// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader
// HD44780-style read engine. Issues one timed read cycle (RW=1) per request,
// either a busy-flag/address-counter read (RS=0) or a data read (RS=1), or in
// poll mode repeats status reads until the busy flag clears or POLL_MAX
// attempts have been made.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req           start request, only looked at in IDLE
//   req_rs        0 = busy/AC read, 1 = data read (ignored when poll=1)
//   poll          sampled with req; repeat status reads until BF=0
//   busy          high from the cycle after acceptance through the done cycle
//   done          one-cycle completion pulse
//   timeout       valid with done; poll ran out of attempts
//   rd_data       last byte captured from the bus
//   busy_flag     bit 7 of the last status read
//   addr_cnt      bits 6:0 of the last status read
//   bus_own       high SETUP..HOLD; pin mux hands the bus to this block
//   lcd_rs/rw/e   LCD control pins
//   lcd_data_in   LCD data pins, input path
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = 2,
  parameter int T_EPW    = 12,
  parameter int T_AH     = 2,
  parameter int T_REC    = 10,
  parameter int POLL_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  input  logic       poll,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       bus_own,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [7:0] lcd_data_in
);

  localparam int T_MAX_A = (T_AS  > T_EPW) ? T_AS  : T_EPW;
  localparam int T_MAX_B = (T_AH  > T_REC) ? T_AH  : T_REC;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX + 1);
  localparam int AW      = $clog2(POLL_MAX + 1);

  lcd_state_t    state, state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_load;
  logic [AW-1:0] attempts;
  logic          attempt_inc;
  logic          timeout_next;
  logic          rs_q;
  logic          poll_q;
  logic          timer_zero;
  logic          phase_own;

  assign timer_zero = (timer == '0);

  // Next-state decision. Each phase lasts until its down-counter reaches
  // zero; the end of RECOVER is where a poll decides between another read
  // and completion, using the busy flag captured in the read just finished.
  always_comb begin
    state_next   = state;
    attempt_inc  = 1'b0;
    timeout_next = timeout;
    unique case (state)
      IDLE: begin
        if (req) state_next = SETUP;
      end
      SETUP: begin
        if (timer_zero) state_next = E_HIGH;
      end
      E_HIGH: begin
        if (timer_zero) state_next = HOLD;
      end
      HOLD: begin
        if (timer_zero) state_next = RECOVER;
      end
      RECOVER: begin
        if (timer_zero) begin
          if (!poll_q || !busy_flag) begin
            state_next   = DONE;
            timeout_next = 1'b0;
          end else if (attempts == AW'(POLL_MAX)) begin
            state_next   = DONE;
            timeout_next = 1'b1;
          end else begin
            state_next  = SETUP;
            attempt_inc = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Phase length for whichever phase is about to be entered. The counter is
  // loaded with length-1 so that it reads zero during the last cycle.
  always_comb begin
    timer_load = '0;
    unique case (state_next)
      SETUP:   timer_load = TW'(T_AS - 1);
      E_HIGH:  timer_load = TW'(T_EPW - 1);
      HOLD:    timer_load = TW'(T_AH - 1);
      RECOVER: timer_load = TW'(T_REC - 1);
      default: timer_load = '0;
    endcase
  end

  // State, phase counter, request latching and bus capture. The bus byte is
  // taken on the last E_HIGH edge, the same edge that drops E, so the LCD
  // has driven the pins for the full pulse width before sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      attempts  <= '0;
      rs_q      <= LCD_RS_CMD;
      poll_q    <= 1'b0;
      timeout   <= 1'b0;
      rd_data   <= '0;
      busy_flag <= 1'b0;
      addr_cnt  <= '0;
    end else begin
      state <= state_next;

      if (state_next != state) begin
        timer <= timer_load;
      end else if (!timer_zero) begin
        timer <= timer - TW'(1);
      end

      if (state == IDLE && req) begin
        rs_q     <= poll ? LCD_RS_CMD : req_rs;
        poll_q   <= poll;
        attempts <= AW'(1);
      end else if (attempt_inc) begin
        attempts <= attempts + AW'(1);
      end

      if (state == E_HIGH && timer_zero) begin
        rd_data <= lcd_data_in;
        if (rs_q == LCD_RS_CMD) begin
          busy_flag <= lcd_data_in[BF_BIT];
          addr_cnt  <= lcd_data_in[6:0];
        end
      end

      if (state == RECOVER && state_next == DONE) begin
        timeout <= timeout_next;
      end
    end
  end

  // Pin and status outputs are pure decodes of the state register, so RS/RW
  // are already stable for the whole SETUP phase before E can rise and a
  // reset takes E low on the very edge that returns the engine to IDLE.
  assign phase_own = (state == SETUP) || (state == E_HIGH) || (state == HOLD);
  assign bus_own   = phase_own;
  assign lcd_rw    = phase_own ? LCD_RW_READ : LCD_RW_WRITE;
  assign lcd_rs    = phase_own ? rs_q : LCD_RS_CMD;
  assign lcd_e     = (state == E_HIGH);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule : lcd_bus_reader
